// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM control unit for a multicycle RISC-V datapath
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset, forces FETCH
//   op         instruction opcode
//   funct3     instruction funct3
//   funct7b5   instruction bit 30
//   Zero       ALU zero flag, qualifies the beq PC write
//   PCWrite    PC enable ((Branch & Zero) | PCUpdate)
//   AdrSrc     memory address select (0 PC, 1 Result)
//   MemWrite   data memory write enable
//   IRWrite    instruction/OldPC register enable
//   ResultSrc  00 ALUOut, 01 Data, 10 ALUResult
//   ALUSrcA    00 PC, 01 OldPC, 10 register A
//   ALUSrcB    00 WriteData, 01 ImmExt, 10 constant 4
//   ImmSrc     00 I, 01 S, 10 B, 11 J
//   RegWrite   register file write enable
//   ALUControl 000 add, 001 sub, 010 and, 011 or, 101 slt
module multicycle_controller (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic [2:0] ALUControl
);
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10
    } state_t;

    state_t     state, next;
    logic [1:0] aluop;
    logic       branch, pcupdate, irw, mw, rw;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= FETCH;
        else          state <= next;

    // Unused encodings fall through to the all-zero default and return to FETCH.
    always_comb begin
        next      = FETCH;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        aluop     = 2'b00;
        branch    = 1'b0;
        pcupdate  = 1'b0;
        irw       = 1'b0;
        mw        = 1'b0;
        rw        = 1'b0;
        case (state)
            FETCH: begin
                irw       = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                pcupdate  = 1'b1;
                next      = DECODE;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                next    = (op == OP_LW || op == OP_SW) ? MEMADR   :
                          (op == OP_R)                 ? EXECUTER :
                          (op == OP_I)                 ? EXECUTEI :
                          (op == OP_BEQ)               ? BEQ      :
                          (op == OP_JAL)               ? JAL      : FETCH;
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                next    = (op == OP_LW) ? MEMREAD : (op == OP_SW) ? MEMWRITE : FETCH;
            end
            MEMREAD: begin
                AdrSrc = 1'b1;
                next   = MEMWB;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                rw        = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc = 1'b1;
                mw     = 1'b1;
            end
            EXECUTER: begin
                ALUSrcA = 2'b10;
                aluop   = 2'b10;
                next    = ALUWB;
            end
            EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                aluop   = 2'b10;
                next    = ALUWB;
            end
            ALUWB: rw = 1'b1;
            JAL: begin
                ALUSrcA  = 2'b01;
                ALUSrcB  = 2'b10;
                pcupdate = 1'b1;
                next     = ALUWB;
            end
            BEQ: begin
                ALUSrcA = 2'b10;
                aluop   = 2'b01;
                branch  = 1'b1;
            end
            default: next = FETCH;
        endcase
    end

    // The state register already sits in FETCH during reset; gating the enables
    // keeps FETCH's IRWrite/PCWrite from reaching the datapath until release.
    always_comb begin
        PCWrite  = reset_n & ((branch & Zero) | pcupdate);
        IRWrite  = reset_n & irw;
        MemWrite = reset_n & mw;
        RegWrite = reset_n & rw;
    end

    always_comb
        ImmSrc = (op == OP_SW)  ? 2'b01 :
                 (op == OP_BEQ) ? 2'b10 :
                 (op == OP_JAL) ? 2'b11 : 2'b00;

    // Subtract only for R-type funct3=000 with bit 30 set; addi ignores bit 30.
    always_comb
        ALUControl = (aluop == 2'b01) ? 3'b001 :
                     (aluop != 2'b10) ? 3'b000 :
                     (funct3 == 3'b000) ? (({op[5], funct7b5} == 2'b11) ? 3'b001 : 3'b000) :
                     (funct3 == 3'b010) ? 3'b101 :
                     (funct3 == 3'b110) ? 3'b011 :
                     (funct3 == 3'b111) ? 3'b010 : 3'b000;
endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have these ports, one per line (name, direction, width, meaning), clock and reset first:
- clk  in  1  single clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- op  in  7  instruction opcode field from the instruction register.
- funct3  in  3  instruction funct3 field.
- funct7b5  in  1  instruction bit 30.
- Zero  in  1  ALU zero flag.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address select: 0 PC, 1 Result.
- MemWrite  out  1  data memory write enable.
- IRWrite  out  1  instruction and OldPC register enable.
- ResultSrc  out  2  result select: 00 ALUOut, 01 Data, 10 ALUResult.
- ALUSrcA  out  2  ALU A select: 00 PC, 01 OldPC, 10 register A.
- ALUSrcB  out  2  ALU B select: 00 register WriteData, 01 ImmExt, 10 constant 4.
- ImmSrc  out  2  immediate format: 00 I, 01 S, 10 B, 11 J.
- RegWrite  out  1  register file write enable.
- ALUControl  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.

Function
REQ-002 The block SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ and JAL.
REQ-003 Every output SHALL be a function of the current state only, except PCWrite, ImmSrc and ALUControl, which also depend on Zero, op and funct inputs as specified below.
REQ-004 Any output not listed for a state SHALL be 0.
REQ-005 State outputs and next state:
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1 -> DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00; op 0000011 -> MEMREAD; op 0100011 -> MEMWRITE.
- MEMREAD: ResultSrc=00, AdrSrc=1 -> MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
- MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1 -> FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 -> ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1 -> ALUWB.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1 -> FETCH.
REQ-006 DECODE next state by op:
- 0000011 or 0100011 -> MEMADR.
- 0110011 -> EXECUTER.
- 0010011 -> EXECUTEI.
- 1100011 -> BEQ.
- 1101111 -> JAL.
- any other op -> FETCH (treated as NOP; no write enable asserted).
REQ-007 PCWrite SHALL equal (Branch AND Zero) OR PCUpdate, combinationally.
REQ-008 ImmSrc SHALL decode from op in every state: 0000011/0010011 -> 00; 0100011 -> 01; 1100011 -> 10; 1101111 -> 11; other -> 00.
REQ-009 ALUControl SHALL be derived from the internal ALUOp: ALUOp 00 -> 000; ALUOp 01 -> 001.
REQ-010 For ALUOp 10, ALUControl SHALL be set by funct3:
- 000 -> 001 if {op[5], funct7b5}=11, else 000.
- 010 -> 101.
- 110 -> 011.
- 111 -> 010.
- other -> 000.
REQ-011 Instruction latencies in clocks, FETCH to the following FETCH exclusive, SHALL be: lw 5, sw 4, R-type 4, I-ALU 4, jal 4, beq 3, unsupported op 2.
REQ-012 The state register SHALL be binary encoded and 4 bits wide; unused encodings SHALL transition to FETCH on the next edge with all write enables 0.

Reset
REQ-013 Asserting reset_n=0 SHALL force the state to FETCH immediately and asynchronously, including mid-instruction, discarding the partial instruction.
REQ-014 While reset_n=0, PCWrite, IRWrite, MemWrite and RegWrite SHALL be 0; mux selects SHALL take their FETCH values; ALUControl SHALL be 000.
REQ-015 On the first rising clk edge after reset_n deasserts, the block SHALL perform FETCH (IRWrite=1, PCWrite=1) and then enter DECODE.

Verification
REQ-016 The bench SHALL cover these directed scenarios:
- lw (op 0000011) after reset -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 only in MEMWB, with ResultSrc=01.
- sw (op 0100011) -> MemWrite=1 exactly one cycle with AdrSrc=1, ImmSrc=01; RegWrite never 1.
- R-type sub (funct3 000, funct7b5=1) -> ALUControl=001 in EXECUTER; R-type with funct3 110 -> ALUControl=011; addi with funct7b5=1 -> 000.
- beq with Zero=1 -> PCWrite=1 in BEQ; beq with Zero=0 -> PCWrite=0; both return to FETCH after 3 cycles.
- jal -> PCWrite=1 in JAL with ALUSrcA=01, ALUSrcB=10, then ALUWB with RegWrite=1.
- Unsupported op 0000000 -> DECODE then FETCH, with no write enable asserted; reset_n pulsed low during MEMREAD -> FETCH, and MemWrite/RegWrite stay 0.
